// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz by default), pix_en strobed.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
`ifdef VGA_FRAME_COUNT_EN
    output logic [7:0] frame_count,
`endif
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       fe_q, fe_d;
    logic [10:0] xw, yw;

    // Flags are derived from the next count so they line up with it.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if ({1'b0, x_q} >= H_LAST) begin
            x_d = '0;
            if ({1'b0, y_q} >= V_LAST) y_d = '0;
            else                       y_d = y_q + 10'd1;
        end
        xw      = {1'b0, x_d};
        yw      = {1'b0, y_d};
        blank_d = (xw < H_VIS) && (yw < V_VIS);
        hs_d    = !((xw >= HS_BEG) && (xw < HS_END));
        vs_d    = !((yw >= VS_BEG) && (yw < VS_END));
        fe_d    = (xw == H_LAST) && (yw == V_LAST);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            fe_q    <= 1'b0;
        end else if (pix_en) begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fe_q    <= fe_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc_q;

    always_ff @(posedge vga_clk) begin
        if (reset)               fc_q <= '0;
        else if (pix_en && fe_q) fc_q <= fc_q + 8'd1;
    end

    assign frame_count = fc_q;
`endif

    assign DrawX     = x_q;
    assign DrawY     = y_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign blank     = blank_q;
    assign frame_end = fe_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: three geometries vs. a pixel-index model.
// Covers default timing lines and small geometries for full frames / counter wrap.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    always #5 clk = ~clk;

    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic       hs [3];
    logic       vs [3];
    logic       bl [3];
    logic       fe [3];
    logic [7:0] fc [3];

    int checks = 0;
    int errors = 0;

    int hv [3] = '{640, 40, 4};
    int hf [3] = '{16, 4, 1};
    int hsw[3] = '{96, 8, 2};
    int hb [3] = '{48, 6, 1};
    int vv [3] = '{480, 20, 3};
    int vf [3] = '{10, 3, 1};
    int vsw[3] = '{2, 2, 1};
    int vb [3] = '{33, 4, 1};

    int pidx  [3];
    int frames[3];

    vga_timing_gen u_def (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .DrawX(dx[0]), .DrawY(dy[0]), .hs(hs[0]), .vs(vs[0]),
        .blank(bl[0]),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(fc[0]),
`endif
        .frame_end(fe[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
        .V_VISIBLE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
    ) u_mid (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .DrawX(dx[1]), .DrawY(dy[1]), .hs(hs[1]), .vs(vs[1]),
        .blank(bl[1]),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(fc[1]),
`endif
        .frame_end(fe[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_tiny (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .DrawX(dx[2]), .DrawY(dy[2]), .hs(hs[2]), .vs(vs[2]),
        .blank(bl[2]),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(fc[2]),
`endif
        .frame_end(fe[2])
    );

`ifndef VGA_FRAME_COUNT_EN
    assign fc[0] = '0;
    assign fc[1] = '0;
    assign fc[2] = '0;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a linear pixel index per frame; coordinates by div/mod.
    task automatic model_step(input int k, input logic r, input logic en);
        int total;
        total = (hv[k] + hf[k] + hsw[k] + hb[k]) * (vv[k] + vf[k] + vsw[k] + vb[k]);
        if (r) begin
            pidx[k]   = 0;
            frames[k] = 0;
        end else if (en) begin
            if (pidx[k] == total - 1) frames[k] = (frames[k] + 1) % 256;
            pidx[k] = (pidx[k] + 1) % total;
        end
    endtask

    task automatic check_inst(input int k);
        int ht, vt, x, y;
        int e_bl, e_hs, e_vs, e_fe;
        ht   = hv[k] + hf[k] + hsw[k] + hb[k];
        vt   = vv[k] + vf[k] + vsw[k] + vb[k];
        x    = pidx[k] % ht;
        y    = pidx[k] / ht;
        e_bl = (x < hv[k] && y < vv[k]) ? 1 : 0;
        e_hs = (x >= hv[k] + hf[k] && x < hv[k] + hf[k] + hsw[k]) ? 0 : 1;
        e_vs = (y >= vv[k] + vf[k] && y < vv[k] + vf[k] + vsw[k]) ? 0 : 1;
        e_fe = (x == ht - 1 && y == vt - 1) ? 1 : 0;
        chk($sformatf("i%0d.DrawX", k), int'(dx[k]), x);
        chk($sformatf("i%0d.DrawY", k), int'(dy[k]), y);
        chk($sformatf("i%0d.blank", k), int'(bl[k]), e_bl);
        chk($sformatf("i%0d.hs", k), int'(hs[k]), e_hs);
        chk($sformatf("i%0d.vs", k), int'(vs[k]), e_vs);
        chk($sformatf("i%0d.frame_end", k), int'(fe[k]), e_fe);
`ifdef VGA_FRAME_COUNT_EN
        chk($sformatf("i%0d.frame_count", k), int'(fc[k]), frames[k]);
`endif
    endtask

    task automatic cycle(input logic r, input logic en);
        @(negedge clk);
        reset  = r;
        pix_en = en;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, en);
        #1;
        for (int k = 0; k < 3; k++) check_inst(k);
    endtask

    initial begin
        int fe_seen;
        reset  = 1'b1;
        pix_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pidx[k]   = 0;
            frames[k] = 0;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        chk("release_dx1", int'(dx[0]), 1);

        // Full-rate stretch covering blank/hs edges on the default geometry.
        for (int i = 0; i < 2400; i++) cycle(1'b0, 1'b1);

        // Random strobe with occasional mid-frame resets.
        for (int i = 0; i < 10000; i++)
            cycle(($urandom_range(499) == 0), ($urandom_range(1) == 1));

        // Dense strobe: many full frames and frame-counter wraps on small geometries.
        fe_seen = 0;
        for (int i = 0; i < 30000; i++) begin
            cycle(1'b0, ($urandom_range(7) != 0));
            if (fe[2]) fe_seen++;
        end
        chk("tiny_frame_end_seen", (fe_seen > 256) ? 1 : 0, 1);

        // Reset with pix_en high must win.
        cycle(1'b1, 1'b1);
        chk("reset_wins_dx", int'(dx[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
